// File: rtl/ppu_issue_ctrl.sv
// Issue/collect controller between ID and the PPU lanes: captures one request, pulses the
// lanes, gathers per-lane results and returns a registered result, with kill and watchdog.
//   state | meaning
//   IDLE  | waiting for en_i; lane valids are stale and ignored
//   ISSUE | one-cycle issue pulse to all lanes; 0-latency results accepted
//   WAIT  | collecting lane results, watchdog running
//   DONE  | one-cycle ready_o (and timeout_o) strobe
//   FLUSH | killed op draining from the lanes, no result reported
module ppu_issue_ctrl #(
    parameter int PPU_NUM        = 1,
    parameter int PPU_OP_WIDTH   = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    kill_i,
    input  logic [31:0]             operand_a_i,
    input  logic [31:0]             operand_b_i,
    input  logic [PPU_OP_WIDTH-1:0] op_i,
    output logic                    ppu_in_valid_o,
    output logic [31:0]             ppu_operand1_o,
    output logic [31:0]             ppu_operand2_o,
    output logic [PPU_OP_WIDTH-1:0] ppu_op_o,
    input  logic [31:0]             ppu_result_i,
    input  logic [PPU_NUM-1:0]      ppu_out_valid_i,
    output logic [31:0]             result_o,
    output logic                    ready_o,
    output logic                    timeout_o,
    output logic                    busy_o
);

    localparam int          LANE_W    = 32 / PPU_NUM;
    localparam logic [7:0]  TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_FLUSH} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             a_q, a_d, b_q, b_d, result_q, result_d;
    logic [PPU_OP_WIDTH-1:0] op_q, op_d;
    logic [PPU_NUM-1:0]      done_q, done_d;
    logic [7:0]              cnt_q, cnt_d, cnt_inc;
    logic                    in_valid_q, in_valid_d, ready_q, ready_d;
    logic                    timeout_q, timeout_d, busy_q, busy_d;
    logic                    all_done, expired;

    assign cnt_inc = cnt_q + 8'd1;
    assign expired = (cnt_inc >= TMO_LIMIT);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        // First valid per lane wins; a killed or flushing op never touches result_o.
        if (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_FLUSH) begin
            for (int i = 0; i < PPU_NUM; i++) begin
                if (ppu_out_valid_i[i] && !done_q[i]) begin
                    done_d[i] = 1'b1;
                    if (state_q != S_FLUSH && !kill_i)
                        result_d[LANE_W*i +: LANE_W] = ppu_result_i[LANE_W*i +: LANE_W];
                end
            end
        end
        all_done = &done_d;

        case (state_q)
            S_IDLE: begin
                if (en_i && !kill_i) begin
                    a_d     = operand_a_i;
                    b_d     = operand_b_i;
                    op_d    = op_i;
                    done_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = kill_i ? S_FLUSH : S_WAIT;
            end
            S_WAIT: begin
                if (kill_i) begin
                    state_d = S_FLUSH;
                end else if (all_done) begin
                    state_d = S_DONE;
                end else if (expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    result_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FLUSH: begin
                if (all_done || expired)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_inc;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        in_valid_d = (state_d == S_ISSUE);
        ready_d    = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            done_q     <= '0;
            cnt_q      <= '0;
            in_valid_q <= 1'b0;
            ready_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            in_valid_q <= in_valid_d;
            ready_q    <= ready_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign ppu_in_valid_o = in_valid_q;
    assign ppu_operand1_o = a_q;
    assign ppu_operand2_o = b_q;
    assign ppu_op_o       = op_q;
    assign result_o       = result_q;
    assign ready_o        = ready_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = busy_q;

endmodule
